// File: rtl/run_monitor.sv
// run_monitor: counts cycles, retired instructions and load-use stalls for one program run, detects halt,
// drains, then dumps a data-memory window over req/ack into a valid/ready stream (RUN_MONITOR_DUMP_EN).
module run_monitor #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                CNT_W        = 32,
    parameter logic [ADDR_W-1:0] DUMP_BASE    = ADDR_W'(8192),
    parameter int                DUMP_WORDS   = 11,
    parameter int                DRAIN_CYCLES = 4,
    parameter logic [DATA_W-1:0] HALT_INSTR   = '1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic              ld_stall,
    output logic              dump_req,
    output logic [ADDR_W-1:0] dump_addr,
    input  logic              dump_ack,
    input  logic [DATA_W-1:0] dump_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic              busy,
    output logic              done
);
    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_REQ, S_OUT, S_DONE} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_cyc, r_ins, r_stl;
    logic [DRW-1:0]   r_drain;
    logic             r_busy, r_done;
    logic             w_is_halt, w_halt;
    assign w_is_halt = instr == HALT_INSTR;
    assign w_halt    = !instr_valid || w_is_halt;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
`ifdef RUN_MONITOR_DUMP_EN
    localparam logic [15:0] LAST = (DUMP_WORDS > 0) ? 16'(DUMP_WORDS - 1) : 16'd0;
    logic              r_req, r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat;
    logic [15:0]       r_idx;
    logic [ADDR_W-1:0] w_next_addr;
    assign w_next_addr = DUMP_BASE + ADDR_W'(r_idx + 16'd1) * ADDR_W'(DATA_W / 8);
    assign dump_req  = r_req;
    assign dump_addr = r_addr;
    assign out_valid = r_vld;
    assign out_data  = r_dat;
    assign out_index = r_idx;
`else
    logic w_unused;
    assign w_unused  = &{1'b0, dump_ack, dump_data, out_ready, DUMP_BASE, DUMP_WORDS[0]};
    assign dump_req  = 1'b0;
    assign dump_addr = '0;
    assign out_valid = 1'b0;
    assign out_data  = '0;
    assign out_index = '0;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_ins   <= '0;
            r_stl   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RUN_MONITOR_DUMP_EN
            r_req   <= 1'b0;
            r_vld   <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
            r_idx   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_state <= S_RUN;
                    r_cyc   <= '0;
                    r_ins   <= '0;
                    r_stl   <= '0;
                    r_drain <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
`ifdef RUN_MONITOR_DUMP_EN
                    r_idx   <= '0;
                    r_addr  <= '0;
`endif
                end
                S_RUN: begin
                    r_cyc <= sat_inc(r_cyc);
                    if (instr_valid && !ld_stall && !w_is_halt) r_ins <= sat_inc(r_ins);
                    if (ld_stall) r_stl <= sat_inc(r_stl);
                    if (w_halt) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_drain <= r_drain + DRW'(1);
                    if (r_drain == DRW'(DRAIN_CYCLES - 1)) begin
`ifdef RUN_MONITOR_DUMP_EN
                        if (DUMP_WORDS == 0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= DUMP_BASE;
                        end
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef RUN_MONITOR_DUMP_EN
                S_REQ: if (dump_ack) begin
                    r_state <= S_OUT;
                    r_req   <= 1'b0;
                    r_vld   <= 1'b1;
                    r_dat   <= dump_data;
                end
                // Accept goes straight to the next request, giving one gap cycle per word.
                S_OUT: if (out_ready) begin
                    r_vld <= 1'b0;
                    if (r_idx == LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_idx   <= r_idx + 16'd1;
                        r_addr  <= w_next_addr;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign cycle_count = r_cyc;
    assign instr_count = r_ins;
    assign stall_count = r_stl;
    assign busy        = r_busy;
    assign done        = r_done;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed and random program runs on three run_monitor configurations, checked against
// a behavioural model that derives counts and halt point from the program table.
module tb_run_monitor;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int D  = 4;
    localparam int NW = 11;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, instr_valid = 1'b0, ld_stall = 1'b0;
    logic [31:0] instr = '0;

    logic        m_req, m_ack = 1'b0, m_valid, m_ready = 1'b0, m_busy, m_done;
    logic [31:0] m_addr, m_data = '0, m_out, m_cyc, m_ins, m_stl;
    logic [15:0] m_idx;

    logic        s_req, s_ack, s_valid, s_busy, s_done;
    logic [31:0] s_addr, s_rd, s_out;
    logic [15:0] s_idx;
    logic [3:0]  s_cyc, s_ins, s_stl;

    logic        z_req, z_valid, z_busy, z_done;
    logic [31:0] z_addr, z_out;
    logic [15:0] z_idx;
    logic [7:0]  z_cyc, z_ins, z_stl;

    logic        s_req_seen = 1'b0, z_req_seen = 1'b0;
    int          checks = 0, errors = 0;
    bit          pv[64], ps[64];
    logic [31:0] pi[64];
    longint      ec[3], en[3], es[3];
    int          cw[3] = '{32, 4, 8};
`ifdef RUN_MONITOR_DUMP_EN
    logic [31:0] mem[NW];
    logic [31:0] s_alog[$];
    logic [47:0] s_olog[$];
`endif

    assign s_ack = s_req;
    assign s_rd  = ~s_addr;

    run_monitor u_main (
        .clock(clock), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
        .ld_stall(ld_stall), .dump_req(m_req), .dump_addr(m_addr), .dump_ack(m_ack), .dump_data(m_data),
        .out_valid(m_valid), .out_ready(m_ready), .out_data(m_out), .out_index(m_idx),
        .cycle_count(m_cyc), .instr_count(m_ins), .stall_count(m_stl), .busy(m_busy), .done(m_done));

    run_monitor #(.CNT_W(4), .DUMP_BASE(32'hFFFF_FFFC), .DUMP_WORDS(2)) u_sat (
        .clock(clock), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
        .ld_stall(ld_stall), .dump_req(s_req), .dump_addr(s_addr), .dump_ack(s_ack), .dump_data(s_rd),
        .out_valid(s_valid), .out_ready(1'b1), .out_data(s_out), .out_index(s_idx),
        .cycle_count(s_cyc), .instr_count(s_ins), .stall_count(s_stl), .busy(s_busy), .done(s_done));

    run_monitor #(.CNT_W(8), .DUMP_WORDS(0)) u_zero (
        .clock(clock), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
        .ld_stall(ld_stall), .dump_req(z_req), .dump_addr(z_addr), .dump_ack(1'b1), .dump_data(32'h0),
        .out_valid(z_valid), .out_ready(1'b1), .out_data(z_out), .out_index(z_idx),
        .cycle_count(z_cyc), .instr_count(z_ins), .stall_count(z_stl), .busy(z_busy), .done(z_done));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (s_req) s_req_seen <= 1'b1;
        if (z_req) z_req_seen <= 1'b1;
`ifdef RUN_MONITOR_DUMP_EN
        if (s_req && s_ack) s_alog.push_back(s_addr);
        if (s_valid) s_olog.push_back({s_idx, s_out});
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Counts follow the run rules directly: every cycle up to and including the halt cycle, saturating.
    function automatic int model(input int w, output longint c, output longint n, output longint s);
        longint mx = (longint'(1) << w) - 1;
        int len = 0;
        c = 0; n = 0; s = 0;
        for (int k = 0; k < 64; k++) begin
            c++;
            if (ps[k]) s++;
            if (pv[k] && !ps[k] && pi[k] != HALT) n++;
            if (!pv[k] || pi[k] == HALT) begin
                len = k + 1;
                break;
            end
        end
        if (c > mx) c = mx;
        if (n > mx) n = mx;
        if (s > mx) s = mx;
        return len;
    endfunction

    function automatic logic [31:0] rnd_i();
        logic [31:0] x = $urandom;
        return (x == HALT) ? 32'h0 : x;
    endfunction

    task automatic fill_random(input int len);
        for (int k = 0; k < len - 1; k++) begin
            pv[k] = 1'b1; ps[k] = ($urandom_range(0, 3) == 0); pi[k] = rnd_i();
        end
        ps[len-1] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) begin
            pv[len-1] = 1'b0; pi[len-1] = rnd_i();
        end else begin
            pv[len-1] = 1'b1; pi[len-1] = HALT;
        end
    endtask

    task automatic chk_counts(input string t);
        chk({t, "_cyc"}, 64'(m_cyc), ec[0]);
        chk({t, "_ins"}, 64'(m_ins), en[0]);
        chk({t, "_stl"}, 64'(m_stl), es[0]);
        chk({t, "_sat_cyc"}, 64'(s_cyc), ec[1]);
        chk({t, "_sat_ins"}, 64'(s_ins), en[1]);
        chk({t, "_sat_stl"}, 64'(s_stl), es[1]);
        chk({t, "_zero_cyc"}, 64'(z_cyc), ec[2]);
        chk({t, "_zero_stl"}, 64'(z_stl), es[2]);
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_req"}, 64'(m_req), 0);
        chk({t, "_addr"}, 64'(m_addr), 0);
        chk({t, "_valid"}, 64'(m_valid), 0);
        chk({t, "_data"}, 64'(m_out), 0);
        chk({t, "_index"}, 64'(m_idx), 0);
        chk({t, "_cyc"}, 64'(m_cyc), 0);
        chk({t, "_ins"}, 64'(m_ins), 0);
        chk({t, "_stl"}, 64'(m_stl), 0);
        chk({t, "_busy"}, 64'({m_busy, s_busy, z_busy}), 0);
        chk({t, "_done"}, 64'({m_done, s_done, z_done}), 0);
    endtask

`ifdef RUN_MONITOR_DUMP_EN
    task automatic dump_main(input int late, input int hold);
        int t;
        for (int w = 0; w < NW; w++) begin
            t = 0;
            while (!m_req && t < 50) begin
                tick();
                t++;
            end
            chk("req_gap", 64'(t), 0);
            chk("req_addr", 64'(m_addr), 64'(32'd8192 + 32'(4 * w)));
            m_ready = 1'b1;
            for (int i = 0; i < late; i++) begin
                tick();
                chk("req_hold", 64'({m_req, m_valid}), 64'(2'b10));
                chk("req_hold_addr", 64'(m_addr), 64'(32'd8192 + 32'(4 * w)));
            end
            m_ready = 1'b0;
            m_ack = 1'b1; m_data = mem[w];
            tick();
            m_data = ~mem[w];
            chk("out_valid", 64'({m_valid, m_req}), 64'(2'b10));
            chk("out_index", 64'(m_idx), 64'(w));
            chk("out_data", 64'(m_out), 64'(mem[w]));
            repeat (hold) tick();
            m_ack = 1'b0;
            chk("out_held", 64'({m_valid, m_idx, m_out}), 64'({1'b1, 16'(w), mem[w]}));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            chk("out_drop", 64'(m_valid), 0);
        end
        chk("dump_done", 64'({m_done, m_busy}), 64'(2'b10));
    endtask
`endif

    task automatic run_prog(input int late, input int hold);
        int len = 0;
        for (int j = 0; j < 3; j++) len = model(cw[j], ec[j], en[j], es[j]);
`ifdef RUN_MONITOR_DUMP_EN
        for (int w = 0; w < NW; w++) mem[w] = $urandom;
        s_alog.delete();
        s_olog.delete();
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_flags", 64'({m_busy, m_done, s_busy, z_busy}), 64'(4'b1011));
        chk("start_counts", 64'({m_cyc, m_ins}), 0);
        for (int k = 0; k < len; k++) begin
            instr_valid = pv[k]; ld_stall = ps[k]; instr = pi[k];
            start = (k > 0) && ($urandom_range(0, 4) == 0);
            tick();
        end
        start = 1'b0;
        chk_counts("halt");
        instr_valid = 1'b1; ld_stall = 1'b1; instr = rnd_i();
        repeat (D - 1) tick();
        chk("drain_flags", 64'({m_busy, m_done, m_req, z_done}), 64'(4'b1000));
        tick();
        chk("zero_done", 64'({z_done, z_busy, z_valid}), 64'(3'b100));
`ifdef RUN_MONITOR_DUMP_EN
        dump_main(late, hold);
        chk("sat_nreq", 64'(s_alog.size()), 2);
        chk("sat_addr0", 64'(s_alog[0]), 64'(32'hFFFF_FFFC));
        chk("sat_addr1_wrap", 64'(s_alog[1]), 0);
        chk("sat_nout", 64'(s_olog.size()), 2);
        chk("sat_out0", 64'(s_olog[0]), 64'({16'd0, 32'h0000_0003}));
        chk("sat_out1", 64'(s_olog[1]), 64'({16'd1, 32'hFFFF_FFFF}));
        chk("sat_done", 64'(s_done), 1);
`else
        chk("done", 64'({m_done, m_busy, s_done}), 64'(3'b101));
        repeat (late + hold) tick();
        chk("done_hold", 64'({m_done, m_busy}), 64'(2'b10));
        chk("dump_tied", 64'({m_req, m_valid, m_addr, m_out, m_idx}), 0);
        chk("sat_never_req", 64'(s_req_seen), 0);
`endif
        chk_counts("hold");
        chk("zero_never_req", 64'(z_req_seen), 0);
        instr_valid = 1'b0; ld_stall = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_zero("rst");
        reset = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            pv[k] = 1'b1; ps[k] = 1'b0; pi[k] = rnd_i();
        end
        pv[10] = 1'b0; ps[10] = 1'b0; pi[10] = rnd_i();
        run_prog(3, 2);
        chk("basic_counts", 64'({m_cyc, m_ins}), 64'({32'd11, 32'd10}));
        chk("basic_stl", 64'(m_stl), 0);
        for (int k = 0; k < 6; k++) begin
            pv[k] = 1'b1; ps[k] = (k == 1 || k == 3 || k == 4); pi[k] = rnd_i();
        end
        pv[6] = 1'b1; ps[6] = 1'b0; pi[6] = HALT;
        run_prog(0, 0);
        chk("stall_counts", 64'({m_cyc, m_ins}), 64'({32'd7, 32'd3}));
        chk("stall_stl", 64'(m_stl), 3);
        for (int k = 0; k < 19; k++) begin
            pv[k] = 1'b1; ps[k] = ($urandom_range(0, 2) == 0); pi[k] = rnd_i();
        end
        pv[19] = 1'b0; ps[19] = 1'b0;
        run_prog(1, 1);
        chk("sat_cyc15", 64'(s_cyc), 15);
        chk("sat_main_cyc20", 64'(m_cyc), 20);
        pv[0] = 1'b0; ps[0] = 1'b0;
        run_prog(0, 1);
        chk("one_cycle_run", 64'(m_cyc), 1);
        for (int r = 0; r < 6; r++) begin
            fill_random($urandom_range(2, 30));
            run_prog($urandom_range(0, 3), $urandom_range(0, 2));
        end
        fill_random(12);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef RUN_MONITOR_DUMP_EN
        for (int k = 0; k < 12; k++) begin
            instr_valid = pv[k]; ld_stall = ps[k]; instr = pi[k];
            tick();
        end
        repeat (D) tick();
        m_ack = 1'b1; m_data = 32'h1234_5678;
        tick();
        m_ack = 1'b0;
        chk("pre_rst_valid", 64'(m_valid), 1);
`else
        for (int k = 0; k < 3; k++) begin
            instr_valid = pv[k]; ld_stall = ps[k]; instr = pi[k];
            tick();
        end
        chk("pre_rst_busy", 64'(m_busy), 1);
        chk("pre_rst_cyc", 64'(m_cyc), 3);
`endif
        #3 reset = 1'b1;
        #1 chk_zero("async_rst");
        instr_valid = 1'b0; ld_stall = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_idle", 64'({m_busy, m_done}), 0);
        for (int k = 0; k < 8; k++) begin
            pv[k] = 1'b1; ps[k] = (k == 2); pi[k] = rnd_i();
        end
        pv[8] = 1'b1; ps[8] = 1'b0; pi[8] = HALT;
        run_prog(2, 1);
        chk("restart_counts", 64'({m_cyc, m_ins}), 64'({32'd9, 32'd7}));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable end-of-run monitor for the multi-cycle/pipelined processor benches. It counts cycles, retired instructions and load-use stalls while a program runs, and detects program termination. It waits a fixed drain period, then reads a parametrised window of data memory word by word over a request/acknowledge port. Each word is presented on a valid/ready output stream, so benches and FPGA harnesses share one halt-and-dump mechanism.

## Interface
Parameters:
- DATA_W, 32, instruction/data word width (multiple of 8)
- ADDR_W, 32, data-memory byte address width
- CNT_W, 32, width of each performance counter
- DUMP_BASE, 8192, byte address of first dumped word
- DUMP_WORDS, 11, number of words dumped (0 allowed)
- DRAIN_CYCLES, 4, cycles waited after halt before dumping (≥1)
- HALT_INSTR, all-ones, instruction encoding treated as halt

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all state
- start  in  1  single-cycle pulse; begins a run
- instr  in  DATA_W  instruction in decode stage
- instr_valid  in  1  instr holds a fetched program instruction
- ld_stall  in  1  pipeline load-use stall this cycle
- dump_req  out  1  memory read request
- dump_addr  out  ADDR_W  byte address of the request
- dump_ack  in  1  memory returns dump_data this cycle
- dump_data  in  DATA_W  read data, valid with dump_ack
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_W  dumped word
- out_index  out  16  word index 0..DUMP_WORDS-1
- cycle_count, instr_count, stall_count  out  CNT_W  counters
- busy  out  1  state not IDLE/DONE
- done  out  1  run and dump complete

## Operation
- States: IDLE, RUN, DRAIN, REQ, OUT, DONE.
- IDLE/DONE + start → RUN. All counters, index and drain counter are cleared in the same edge. start is ignored in other states.
- RUN: cycle_count +1 every cycle, including the halt cycle.
  - instr_count +1 when instr_valid && !ld_stall && instr≠HALT_INSTR.
  - stall_count +1 when ld_stall.
  - Halt when !instr_valid || instr==HALT_INSTR → DRAIN.
- Counters saturate at all-ones and hold outside RUN.
- DRAIN: counts DRAIN_CYCLES cycles. Then → REQ, or → DONE if DUMP_WORDS==0.
- REQ: dump_req=1, dump_addr = DUMP_BASE + index·(DATA_W/8), modulo 2^ADDR_W.
  - Request and address are held stable until dump_ack.
  - On the dump_ack edge, capture dump_data into out_data → OUT.
- OUT: out_valid=1 with data and index held until out_ready.
  - On the accept edge, if index==DUMP_WORDS-1 → DONE; else index+1 → REQ.
- dump_ack outside REQ and out_ready outside OUT are ignored.
- DONE: done=1, counters hold, waits for start.

## Timing
- Reset values:
  - All outputs 0; dump_addr 0; state IDLE.
  - Reset mid-run or mid-dump aborts immediately with no output.
- start at edge N → busy=1 after N. First counted cycle is N+1.
- Halt seen at edge H → DRAIN after H. dump_req rises after edge H+DRAIN_CYCLES.
- Ack at edge A → out_valid=1 after A.
- Accept at edge B → dump_req for the next word after B, i.e. one idle cycle between words. Minimum 2 cycles per word.
- A combinational ack in the first REQ cycle is legal.
- done rises the cycle after the last accept. busy and done are never both 1.

## Configuration
- RUN_MONITOR_DUMP_EN defined: dump path as above.
- Undefined:
  - REQ/OUT removed; DRAIN → DONE directly.
  - dump_req, dump_addr, out_valid, out_data, out_index tied 0.
  - dump_ack, dump_data, out_ready unused.
  - Counters and timing otherwise identical.

## Test plan
- Basic run:
  - Stimulus: start, 10 valid non-halt instrs with no stalls, then instr_valid=0.
  - Expect: cycle_count=11, instr_count=10, stall_count=0.
  - Expect: dump_req after 4 drain cycles with dump_addr 8192, 8196, …, 8232.
- Stalls:
  - Stimulus: 6 instrs, ld_stall high for 3 of those cycles, then HALT_INSTR.
  - Expect: instr_count=3, stall_count=3, cycle_count=7.
- Backpressure:
  - Stimulus: dump_ack 3 cycles late per word; out_ready low 2 cycles per word.
  - Expect: exactly 11 words emitted, index 0..10 in order, data matching memory contents, no drops or duplicates; done=1 after the 11th accept.
- Edge cases:
  - DUMP_WORDS=0 → DONE straight after drain, dump_req never asserted.
  - DUMP_BASE=2^ADDR_W−4 → second address wraps to 0.
- Reset and restart:
  - Reset asserted while in OUT → all outputs 0 asynchronously.
  - Subsequent start → fresh run from count 0.
  - start pulsed during RUN → ignored, counts unaffected.
- Saturation: CNT_W=4 with 20-cycle run → cycle_count=15.
